// File: rtl/status_cond_unit.sv
// Status register {Z,C,N,V}, ALU carry-in, condition evaluation and
// flag-hazard stall tracking between the ID and EX stages.
module status_cond_unit #(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_set_flags,
  input  logic [3:0]       ex_sr,
  input  logic             ex_sr_we,
  input  logic             ex_sr_drop,
  output logic             stall,
  output logic             cond_pass,
  output logic [3:0]       sr,
  output logic             carry,
  output logic [CNT_W-1:0] pending,
  output logic             err
);

  logic [3:0]       sr_q;
  logic [3:0]       sr_d;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_d;
  logic [CNT_W-1:0] pend_after;
  logic             err_q;
  logic             err_d;
  logic             dec;
  logic             issue;
  logic             cond_true;
  logic [3:0]       flags_eff;
  logic             f_z;
  logic             f_c;
  logic             f_n;
  logic             f_v;

  assign dec = ex_sr_we | ex_sr_drop;

  // Retirement floors at zero; a stray retire only raises err.
  assign pend_after = (dec && pend_q != '0)
                    ? pend_q - 1'b1
                    : pend_q;

  // Same-cycle bypass of the EX write; reset pins evaluation to sr=0.
  assign flags_eff = (ex_sr_we && rst_n) ? ex_sr : sr_q;
  assign {f_z, f_c, f_n, f_v} = flags_eff;

  assign stall = id_valid
               & ((id_cond != 4'b1110 & pend_after != '0)
                | (id_set_flags
                 & pend_after == CNT_W'(PIPE_DEPTH)));

  assign issue = id_valid & ~stall;

  always_comb begin
    cond_true = 1'b0;
    unique case (id_cond)
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = ~f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = ~f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = ~f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = ~f_v;
      4'b1000: cond_true = f_c & ~f_z;
      4'b1001: cond_true = ~f_c | f_z;
      4'b1010: cond_true = f_n == f_v;
      4'b1011: cond_true = f_n != f_v;
      4'b1100: cond_true = ~f_z & (f_n == f_v);
      4'b1101: cond_true = f_z | (f_n != f_v);
      4'b1110: cond_true = 1'b1;
      4'b1111: cond_true = 1'b0;
    endcase
  end

  assign cond_pass = issue & cond_true;

  assign sr_d   = ex_sr_we ? ex_sr : sr_q;
  assign pend_d = pend_after
                + {{(CNT_W-1){1'b0}}, issue & id_set_flags};
  assign err_d  = err_q
                | (dec & pend_q == '0)
                | (ex_sr_we & ex_sr_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= 4'b0000;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign sr      = sr_q;
  assign carry   = sr_q[2];
  assign pending = pend_q;
  assign err     = err_q;

endmodule

// File: tb/tb_status_cond_unit.sv
// Self-checking bench for status_cond_unit: directed scenarios plus
// randomized traffic checked every cycle against a behavioural model.
module tb_status_cond_unit;

  localparam int PD = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_cond = 4'b0;
  logic          id_set_flags = 1'b0;
  logic [3:0]    ex_sr = 4'b0;
  logic          ex_sr_we = 1'b0;
  logic          ex_sr_drop = 1'b0;
  logic          stall;
  logic          cond_pass;
  logic [3:0]    sr;
  logic          carry;
  logic [CW-1:0] pending;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;

  int         m_pend = 0;
  logic [3:0] m_sr = 4'b0;
  logic       m_err = 1'b0;

  status_cond_unit #(.PIPE_DEPTH(PD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_cond(id_cond),
    .id_set_flags(id_set_flags),
    .ex_sr(ex_sr), .ex_sr_we(ex_sr_we),
    .ex_sr_drop(ex_sr_drop),
    .stall(stall), .cond_pass(cond_pass),
    .sr(sr), .carry(carry),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Condition table written directly from the named flags.
  function automatic logic cond_f(input logic [3:0] c,
                                  input logic [3:0] f);
    logic z, cy, n, v;
    {z, cy, n, v} = f;
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare process: model outputs vs DUT every cycle, then model update.
  always begin
    int         pa, nx_pend;
    logic [3:0] fl, nx_sr;
    logic       st, iss, nx_err, dec;
    @(negedge clk);
    #3;
    if (!rst_n) begin
      m_pend = 0; m_sr = 4'b0; m_err = 1'b0;
    end
    dec = ex_sr_we || ex_sr_drop;
    pa  = (dec && m_pend > 0) ? m_pend - 1 : m_pend;
    fl  = (ex_sr_we && rst_n) ? ex_sr : m_sr;
    st  = id_valid && ((id_cond != 4'd14 && pa != 0)
                    || (id_set_flags && pa == PD));
    iss = id_valid && !st;
    chk("stall", 32'(stall), 32'(st));
    chk("cond_pass", 32'(cond_pass),
        32'(iss && cond_f(id_cond, fl)));
    chk("sr", 32'(sr), 32'(m_sr));
    chk("carry", 32'(carry), 32'(m_sr[2]));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("err", 32'(err), 32'(m_err));
    nx_sr   = ex_sr_we ? ex_sr : m_sr;
    nx_pend = pa + ((iss && id_set_flags) ? 1 : 0);
    nx_err  = m_err || (dec && m_pend == 0)
                    || (ex_sr_we && ex_sr_drop);
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_sr = nx_sr; m_pend = nx_pend; m_err = nx_err;
    end
  end

  task automatic set(input logic v, input logic [3:0] c,
                     input logic s, input logic [3:0] x,
                     input logic we, input logic dr);
    id_valid = v; id_cond = c; id_set_flags = s;
    ex_sr = x; ex_sr_we = we; ex_sr_drop = dr;
  endtask

  task automatic idle();
    set(0, 4'd0, 0, 4'd0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Flag hazard resolved by same-cycle bypass.
    set(1, 4'b1110, 1, 4'd0, 0, 0);
    @(negedge clk);
    set(1, 4'b0000, 0, 4'd0, 0, 0);
    #4;
    chk("hz_pend1", 32'(pending), 32'd1);
    chk("hz_stall", 32'(stall), 32'd1);
    @(negedge clk);
    set(1, 4'b0000, 0, 4'b1000, 1, 0);
    #4;
    chk("hz_bypass_stall", 32'(stall), 32'd0);
    chk("hz_bypass_pass", 32'(cond_pass), 32'd1);
    @(negedge clk);
    idle();
    #4;
    chk("hz_sr", 32'(sr), 32'h8);
    chk("hz_pend0", 32'(pending), 32'd0);
    @(negedge clk);

    // Clear sr to 0000 while keeping one instruction in flight.
    set(1, 4'b1110, 1, 4'd0, 0, 0);
    @(negedge clk);
    set(1, 4'b1110, 1, 4'b0000, 1, 0);
    @(negedge clk);
    set(1, 4'b0000, 0, 4'b1111, 0, 1);
    #4;
    chk("drop_stall", 32'(stall), 32'd0);
    chk("drop_pass", 32'(cond_pass), 32'd0);
    @(negedge clk);
    idle();
    #4;
    chk("drop_sr", 32'(sr), 32'h0);
    chk("drop_pend", 32'(pending), 32'd0);
    @(negedge clk);

    // Full pipeline of flag setters.
    repeat (3) begin
      set(1, 4'b1110, 1, 4'd0, 0, 0);
      @(negedge clk);
    end
    set(1, 4'b1110, 1, 4'd0, 0, 0);
    #4;
    chk("full_pend", 32'(pending), 32'd3);
    chk("full_s_stall", 32'(stall), 32'd1);
    @(negedge clk);
    set(1, 4'b1110, 0, 4'd0, 0, 0);
    #4;
    chk("full_al_stall", 32'(stall), 32'd0);
    chk("full_al_pass", 32'(cond_pass), 32'd1);
    @(negedge clk);
    set(1, 4'b1110, 1, 4'b0011, 1, 0);
    #4;
    chk("full_swap_stall", 32'(stall), 32'd0);
    @(negedge clk);
    idle();
    #4;
    chk("full_swap_pend", 32'(pending), 32'd3);
    chk("full_carry", 32'(carry), 32'd0);
    @(negedge clk);
    repeat (3) begin
      set(0, 4'd0, 0, 4'd0, 0, 1);
      @(negedge clk);
    end

    // Condition sweep over every sr value and condition code.
    for (int s = 0; s < 16; s++) begin
      set(1, 4'b1110, 1, 4'd0, 0, 0);
      @(negedge clk);
      set(0, 4'd0, 0, 4'(s), 1, 0);
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
        set(1, 4'(c), 0, 4'd0, 0, 0);
        #4;
        chk("sweep", 32'(cond_pass), 32'(cond_f(4'(c), 4'(s))));
        if (s == 5) begin
          if (c == 10) chk("sr5_GE", 32'(cond_pass), 32'd0);
          if (c == 11) chk("sr5_LT", 32'(cond_pass), 32'd1);
          if (c == 8)  chk("sr5_HI", 32'(cond_pass), 32'd1);
          if (c == 12) chk("sr5_GT", 32'(cond_pass), 32'd0);
          if (c == 0)  chk("sr5_carry", 32'(carry), 32'd1);
        end
        @(negedge clk);
      end
    end

    // Asynchronous reset mid-run with pending=2, sr=1010.
    repeat (3) begin
      set(1, 4'b1110, 1, 4'd0, 0, 0);
      @(negedge clk);
    end
    set(0, 4'd0, 0, 4'b1010, 1, 0);
    @(negedge clk);
    set(1, 4'b0001, 0, 4'd0, 0, 0);
    #2;
    chk("pre_rst_pend", 32'(pending), 32'd2);
    chk("pre_rst_sr", 32'(sr), 32'ha);
    rst_n = 1'b0;
    #1;
    chk("rst_sr", 32'(sr), 32'h0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pass", 32'(cond_pass), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Protocol errors.
    set(0, 4'd0, 0, 4'b0110, 1, 0);
    @(negedge clk);
    idle();
    #4;
    chk("err_sr", 32'(sr), 32'h6);
    chk("err_set", 32'(err), 32'd1);
    chk("err_pend", 32'(pending), 32'd0);
    repeat (3) @(negedge clk);
    #4;
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    repeat (2) begin
      set(1, 4'b1110, 1, 4'd0, 0, 0);
      @(negedge clk);
    end
    set(0, 4'd0, 0, 4'b1111, 1, 1);
    @(negedge clk);
    idle();
    #4;
    chk("both_pend", 32'(pending), 32'd1);
    chk("both_sr", 32'(sr), 32'hf);
    chk("both_err", 32'(err), 32'd1);
    @(negedge clk);

    // Randomized traffic, including stray retires and async resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = 1'b1;
      id_valid     = ($urandom_range(0, 3) != 0);
      id_cond      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) id_cond = 4'b1110;
      id_set_flags = ($urandom_range(0, 1) != 0);
      ex_sr        = 4'($urandom_range(0, 15));
      ex_sr_we     = ($urandom_range(0, 3) == 0);
      ex_sr_drop   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst_n = 1'b0;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Holds the architectural status register {Z,C,N,V} written by the EX-stage ALU.
- Gives the ALU its carry-in.
- Evaluates the 4-bit condition field of the decode-stage instruction against current or bypassed flags.
- Tracks in-flight flag-setting instructions and stalls decode until the flags a conditional instruction depends on have resolved.
- Sits between the ID stage (consumer of stall/cond_pass) and the EX stage (producer of SR).

Parameters:
- PIPE_DEPTH, 3: max issued-but-uncommitted flag-setting instructions.
- CNT_W, 2: pending counter width; 2^CNT_W-1 >= PIPE_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage presents an instruction.
- id_cond  in  4  condition field of that instruction.
- id_set_flags  in  1  decode instruction has S=1 and will write SR.
- ex_sr  in  4  ALU status {Z,C,N,V}; bit3=Z, bit2=C, bit1=N, bit0=V.
- ex_sr_we  in  1  oldest issued S-instruction commits ex_sr this cycle.
- ex_sr_drop  in  1  oldest issued S-instruction was squashed; no write.
- stall  out  1  decode must hold; nothing issues.
- cond_pass  out  1  condition true; meaningful only when stall=0.
- sr  out  4  status register, same bit order as ex_sr.
- carry  out  1  sr[2], carry-in to the ALU.
- pending  out  CNT_W  in-flight S-instruction count.
- err  out  1  sticky protocol-error flag.

Behaviour:

Reset:
- rst_n=0 asynchronously forces sr=0000, pending=0, err=0 regardless of clock; in-flight state is discarded.
- While in reset, stall=0 and cond_pass is evaluated against sr=0000.

Retire and bypass (combinational):
- dec = ex_sr_we | ex_sr_drop.
- pend_after = pending - dec, floored at 0.
- flags_eff = ex_sr_we ? ex_sr : sr. The same-cycle bypass means an EX write is visible to decode with zero latency.

Stall (combinational):
- stall = id_valid & ((id_cond != 1110 & pend_after != 0) | (id_set_flags & pend_after == PIPE_DEPTH)).
- AL (1110) instructions never stall on flags.
- issue = id_valid & ~stall.

Condition evaluation on flags_eff (combinational):
- EQ 0000: Z.
- NE 0001: ~Z.
- CS 0010: C.
- CC 0011: ~C.
- MI 0100: N.
- PL 0101: ~N.
- VS 0110: V.
- VC 0111: ~V.
- HI 1000: C&~Z.
- LS 1001: ~C|Z.
- GE 1010: N==V.
- LT 1011: N!=V.
- GT 1100: ~Z&(N==V).
- LE 1101: Z|(N!=V).
- AL 1110: 1.
- NV 1111: 0.
- cond_pass = issue & table(id_cond). It is 0 when stalled or when id_valid=0.

Status register (registered, 1-cycle latency to the sr output):
- sr <= ex_sr on the clk edge when ex_sr_we=1; otherwise sr holds.

Pending counter:
- Next value = pending + (issue & id_set_flags) - dec.
- Simultaneous increment and decrement leaves it unchanged.
- An S-instruction with a failing condition still counts; EX must still retire it via ex_sr_we or ex_sr_drop.

Protocol errors (err is set and stays set until reset):
- dec with pending=0: counter stays 0; sr is still written if ex_sr_we=1.
- ex_sr_we & ex_sr_drop in the same cycle: treated as one write (sr <= ex_sr) and one decrement.
- The counter never exceeds PIPE_DEPTH; the stall rule guarantees this.

Test Plan:
- Reset: rst_n=0 mid-run with pending=2 and sr=1010 -> sr=0000, pending=0, err=0 immediately without a clock edge; id_cond=0001 (NE) with id_valid=1 -> stall=0, cond_pass=1.
- Flag hazard: issue id_set_flags=1 (AL) -> pending=1. Next cycle id_cond=0000 (EQ) -> stall=1 until ex_sr_we=1 with ex_sr=1000; in that same cycle stall=0 and cond_pass=1 via bypass. Next edge: sr=1000, pending=0.
- Drop path: pending=1, EQ waiting, ex_sr_drop=1 -> stall=0, flags_eff=old sr=0000, cond_pass=0, sr unchanged, pending=0.
- Full: issue PIPE_DEPTH=3 AL S-instructions with no retire -> pending=3. A 4th S-instruction stalls; an AL non-S instruction does not stall. One ex_sr_we with a simultaneous new S-issue -> pending remains 3.
- Condition sweep: for each sr in 0000..1111, for all 16 id_cond values with pending=0 -> cond_pass matches the table (256 checks), e.g. sr=0101 (C=1, V=1): GE=0, LT=1, HI=1, GT=0.
- Errors: ex_sr_we=1 with pending=0 and ex_sr=0110 -> sr=0110, err=1 and sticky. ex_sr_we & ex_sr_drop together with pending=2 -> pending=1, sr updated, err=1.
